// File: rtl/cv32e40px_x_result_arb_pkg.sv
// cv32e40px_x_result_arb_pkg
//   Shared types, limits and the round-robin pick helper for the X-interface
//   result arbiter (cv32e40px_x_result_arb) and its pointer sub-module
//   (cv32e40px_x_rr_arbiter).
//   Contents:
//     X_RESULT_ARB_MAX_COPROC : largest supported number of coprocessors
//     X_RESULT_ARB_IDX_W      : width of an index able to address any coprocessor
//     x_result_t              : result payload {id, rd, we, data} at default widths
//     rr_pick_t               : {found, idx} answer from rr_pick
//     rr_pick()               : first valid requester at or after a pointer, wrapping
package cv32e40px_x_result_arb_pkg;

  localparam int unsigned X_RESULT_ARB_MAX_COPROC = 8;
  localparam int unsigned X_RESULT_ARB_IDX_W      = 3;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [0:0]  we;
    logic [31:0] data;
  } x_result_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scan valid[] starting at ptr and wrapping at num-1 -> 0; the first set bit wins.
  // Only the low num bits of valid take part in the scan.
  function automatic rr_pick_t rr_pick(input logic [7:0] valid,
                                       input logic [2:0] ptr,
                                       input int unsigned num);
    rr_pick_t    res;
    int unsigned j;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int unsigned i = 0; i < X_RESULT_ARB_MAX_COPROC; i++) begin
      j = int'(ptr) + i;
      if (j >= num) begin
        j = j - num;
      end else begin
        j = j;
      end
      if ((i < num) && !res.found && valid[j[2:0]]) begin
        res.found = 1'b1;
        res.idx   = j[2:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cv32e40px_x_rr_arbiter.sv
// cv32e40px_x_rr_arbiter
//   Combinational round-robin pick over NUM_COPROC requesters plus the
//   registered priority pointer (index of the highest-priority requester).
//   The pointer moves to winner+1 (wrapping) only when a grant is issued.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset (pointer -> 0)
//     valid_i       : per-requester request
//     advance_i     : grant may be issued this cycle (output slot free and not in reset)
//     grant_o       : one-hot grant, all zero when advance_i is low or nothing requests
//     winner_o      : index of the picked requester (valid when found_o)
//     found_o       : at least one requester is valid
module cv32e40px_x_rr_arbiter
  import cv32e40px_x_result_arb_pkg::*;
#(
  parameter int unsigned NUM_COPROC = 2,
  localparam int unsigned PTR_W = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_COPROC-1:0] valid_i,
  input  logic                  advance_i,
  output logic [NUM_COPROC-1:0] grant_o,
  output logic [2:0]            winner_o,
  output logic                  found_o
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       valid_ext_s;
  logic [2:0]       next_idx_s;
  rr_pick_t         pick_s;

  // Round-robin pick starting at the pointer; grant only when the slot can take it.
  always_comb begin
    valid_ext_s                 = 8'h00;
    valid_ext_s[NUM_COPROC-1:0] = valid_i;
    pick_s                      = rr_pick(valid_ext_s, 3'(rr_ptr_q), NUM_COPROC);
    grant_o                     = {NUM_COPROC{1'b0}};
    for (int i = 0; i < int'(NUM_COPROC); i++) begin
      grant_o[i] = advance_i & pick_s.found & (pick_s.idx == 3'(i));
    end
  end

  assign winner_o = pick_s.idx;
  assign found_o  = pick_s.found;

  // Next pointer: one past the winner on a grant, otherwise unchanged.
  always_comb begin
    if (pick_s.idx >= 3'(NUM_COPROC - 1)) begin
      next_idx_s = 3'd0;
    end else begin
      next_idx_s = pick_s.idx + 3'd1;
    end
    if (advance_i && pick_s.found) begin
      rr_ptr_d = PTR_W'(next_idx_s);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= {PTR_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/cv32e40px_x_result_arb.sv
// cv32e40px_x_result_arb
//   Round-robin arbiter and output register between NUM_COPROC coprocessor
//   result channels and the single core-side X-interface result channel.
//   A coprocessor handshake (valid & ready, same cycle) loads the output
//   register on the next edge; the output is held until the core accepts it.
//   Accept and a new grant can happen on the same edge (1 result per cycle).
//   Optional feature: macro CV32E40PX_X_RESULT_ARB_PERF_EN adds
//   x_result_conflict_cnt_o, a saturating 16-bit count of cycles in which some
//   coprocessor was valid but not granted.
//   Ports:
//     clk_i, rst_ni          : clock, synchronous active-low reset
//     cp_result_valid_i      : per-coprocessor result valid
//     cp_result_ready_o      : per-coprocessor ready (one-hot or zero, zero in reset)
//     cp_result_id/rd/we/data_i : per-coprocessor result payload
//     x_result_valid_o       : core-side result valid
//     x_result_ready_i       : core-side result ready
//     x_result_id/rd/we/data_o : registered payload
//     x_result_src_o         : index of the coprocessor that produced the result
//     x_result_conflict_cnt_o: (optional) conflict cycle counter
module cv32e40px_x_result_arb
  import cv32e40px_x_result_arb_pkg::*;
#(
  parameter int unsigned NUM_COPROC  = 2,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32,
  parameter int unsigned X_DUALWRITE = 0,
  localparam int unsigned SRC_W = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1,
  localparam int unsigned WE_W  = X_DUALWRITE + 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_COPROC-1:0]                   cp_result_valid_i,
  output logic [NUM_COPROC-1:0]                   cp_result_ready_o,
  input  logic [NUM_COPROC-1:0][X_ID_WIDTH-1:0]   cp_result_id_i,
  input  logic [NUM_COPROC-1:0][4:0]              cp_result_rd_i,
  input  logic [NUM_COPROC-1:0][WE_W-1:0]         cp_result_we_i,
  input  logic [NUM_COPROC-1:0][X_RFW_WIDTH-1:0]  cp_result_data_i,
  output logic                                    x_result_valid_o,
  input  logic                                    x_result_ready_i,
  output logic [X_ID_WIDTH-1:0]                   x_result_id_o,
  output logic [4:0]                              x_result_rd_o,
  output logic [WE_W-1:0]                         x_result_we_o,
  output logic [X_RFW_WIDTH-1:0]                  x_result_data_o,
  output logic [SRC_W-1:0]                        x_result_src_o
`ifdef CV32E40PX_X_RESULT_ARB_PERF_EN
  ,
  output logic [15:0]                             x_result_conflict_cnt_o
`endif
);

  logic                    out_valid_q, out_valid_d;
  logic [X_ID_WIDTH-1:0]   id_q, id_d;
  logic [4:0]              rd_q, rd_d;
  logic [WE_W-1:0]         we_q, we_d;
  logic [X_RFW_WIDTH-1:0]  data_q, data_d;
  logic [SRC_W-1:0]        src_q, src_d;

  logic                    load_en_s;
  logic                    advance_s;
  logic                    handshake_s;
  logic                    found_s;
  logic [2:0]              winner_s;
  logic [NUM_COPROC-1:0]   grant_s;
  logic [X_ID_WIDTH-1:0]   sel_id_s;
  logic [4:0]              sel_rd_s;
  logic [WE_W-1:0]         sel_we_s;
  logic [X_RFW_WIDTH-1:0]  sel_data_s;

  // The slot can take a new result when empty or being drained this cycle;
  // rst_ni gates ready so nothing is handshaken while reset is asserted.
  assign load_en_s = ~out_valid_q | x_result_ready_i;
  assign advance_s = load_en_s & rst_ni;

  cv32e40px_x_rr_arbiter #(
    .NUM_COPROC (NUM_COPROC)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (cp_result_valid_i),
    .advance_i (advance_s),
    .grant_o   (grant_s),
    .winner_o  (winner_s),
    .found_o   (found_s)
  );

  assign cp_result_ready_o = grant_s;
  assign handshake_s       = |grant_s;

  // One-hot AND-OR payload mux driven by the grant vector.
  always_comb begin
    sel_id_s   = {X_ID_WIDTH{1'b0}};
    sel_rd_s   = 5'd0;
    sel_we_s   = {WE_W{1'b0}};
    sel_data_s = {X_RFW_WIDTH{1'b0}};
    for (int i = 0; i < int'(NUM_COPROC); i++) begin
      sel_id_s   = sel_id_s   | ({X_ID_WIDTH{grant_s[i]}}  & cp_result_id_i[i]);
      sel_rd_s   = sel_rd_s   | ({5{grant_s[i]}}           & cp_result_rd_i[i]);
      sel_we_s   = sel_we_s   | ({WE_W{grant_s[i]}}        & cp_result_we_i[i]);
      sel_data_s = sel_data_s | ({X_RFW_WIDTH{grant_s[i]}} & cp_result_data_i[i]);
    end
  end

  // Output register next state: load on grant, clear valid on a bare accept,
  // otherwise hold. Payload keeps its last value after the accept.
  always_comb begin
    id_d   = id_q;
    rd_d   = rd_q;
    we_d   = we_q;
    data_d = data_q;
    src_d  = src_q;
    if (handshake_s) begin
      out_valid_d = 1'b1;
      id_d        = sel_id_s;
      rd_d        = sel_rd_s;
      we_d        = sel_we_s;
      data_d      = sel_data_s;
      src_d       = (NUM_COPROC == 1) ? {SRC_W{1'b0}} : SRC_W'(winner_s);
    end else if (out_valid_q && x_result_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register; reset discards any pending result without a handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      id_q        <= {X_ID_WIDTH{1'b0}};
      rd_q        <= 5'd0;
      we_q        <= {WE_W{1'b0}};
      data_q      <= {X_RFW_WIDTH{1'b0}};
      src_q       <= {SRC_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      data_q      <= data_d;
      src_q       <= src_d;
    end
  end

  assign x_result_valid_o = out_valid_q;
  assign x_result_id_o    = id_q;
  assign x_result_rd_o    = rd_q;
  assign x_result_we_o    = we_q;
  assign x_result_data_o  = data_q;
  assign x_result_src_o   = src_q;

`ifdef CV32E40PX_X_RESULT_ARB_PERF_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict_s;

  // A conflict cycle: some coprocessor is valid but not granted.
  assign conflict_s = |(cp_result_valid_i & ~cp_result_ready_o);

  // Saturating conflict counter next state.
  always_comb begin
    if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign x_result_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
